dht11_sensor_model: RTL and testbench
=====================================

// Module: dht11_sensor_model
// PURPOSE
//  Synthesisable DHT11 sensor responder, the device end of the single-wire DHT11 protocol.
//  Waits for a host start pulse, then answers with the response preamble and a 40-bit frame.
//  Frame: hum_int, 0x00, temp_int, 0x00, checksum; MSB first.
//  Sits on the bus next to the on-chip DHT11 host (loop-back self-test) or drives a pin for external hosts.
// PARAMETERS (all in clk cycles, defaults for 100 MHz)
//  START_MIN_CYC  500_000  minimum host low time that qualifies as a start request (5 ms)
//  WAIT_CYC       3_000    delay from host release to response low (30 us)
//  RESP_LOW_CYC   8_000    response low phase (80 us)
//  RESP_HIGH_CYC  8_000    response released/high phase (80 us)
//  BIT_LOW_CYC    5_000    low phase before every data bit, and the end-of-frame low (50 us)
//  BIT_H0_CYC     2_600    high phase for a '0' bit (26 us)
//  BIT_H1_CYC     7_000    high phase for a '1' bit (70 us)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  dht_i        in   1   bus level (asynchronous, pad input)
//  dht_o        out  1   bus drive value; constant 0 (open-drain)
//  dht_o_en     out  1   1 = pull bus low; 0 = release to pull-up
//  humidity     in   8   humidity integer byte, sampled at start qualification
//  temperature  in   8   temperature integer byte, sampled at start qualification
//  busy         out  1   high from start qualification until return to IDLE
//  frame_done   out  1   one-cycle pulse when end-of-frame low completes
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset values: dht_o=0, dht_o_en=0, busy=0, frame_done=0, state=IDLE, all counters 0.
//  - Reset mid-frame: bus released on the first edge with rst=1; no partial-frame resumption.
//  - dht_i passes through a 2-FF synchronizer; all decisions use the synced level.
//    The synchronizer adds 2 cycles of latency.
//  - dht_o_en is registered. High only in RESP_LOW, BIT_LOW and END_LOW; 0 in all other states.
//  - State machine; cnt resets to 0 on every state change:
//    * IDLE: on synced low -> HOST_LOW.
//    * HOST_LOW: cnt++ while low.
//      - Rises with cnt < START_MIN_CYC -> IDLE, glitch ignored.
//      - On cnt == START_MIN_CYC: latch the frame; busy=1.
//      - On release after qualification -> WAIT.
//      - Host may hold low indefinitely.
//    * WAIT: after WAIT_CYC -> RESP_LOW.
//    * RESP_LOW: after RESP_LOW_CYC -> RESP_HIGH.
//    * RESP_HIGH: after RESP_HIGH_CYC -> BIT_LOW.
//    * BIT_LOW: after BIT_LOW_CYC -> BIT_HIGH.
//    * BIT_HIGH: after BIT_H1_CYC if the bit is 1, else BIT_H0_CYC.
//      - Bit index 6-bit, 0..39.
//      - If index==39 -> END_LOW; else index++ and -> BIT_LOW.
//    * END_LOW: after BIT_LOW_CYC -> IDLE; frame_done=1 for one cycle; busy=0.
//  - Checksum = (hum + 0 + temp + 0) mod 256, computed in 8 bits with carry discarded.
//  - Frame latched as 40-bit shift register {hum,8'h00,temp,8'h00,csum}; bit 39 sent first.
//  - humidity/temperature changes after qualification do not affect the frame in flight.
//  - Bus activity from BIT_LOW through END_LOW is ignored. No collision detection.
//  - Host activity during WAIT..END_LOW is not re-qualified; a new start is seen only in IDLE.
//  - Bus seen low immediately on entering IDLE (host already pulling) begins a fresh HOST_LOW count.
// CONFIGURATION
//  DHT11_ERR_INJECT_EN defined:
//    - Adds input port err_inject (1 bit).
//    - If err_inject=1 at the qualification cycle, the latched checksum is bitwise inverted.
//  DHT11_ERR_INJECT_EN undefined:
//    - Port absent; checksum always correct.
// STRUCTURE
//  - dht11_pkg: state_t enum {IDLE,HOST_LOW,WAIT,RESP_LOW,RESP_HIGH,BIT_LOW,BIT_HIGH,END_LOW}.
//    Also holds timing default localparams and FRAME_BITS=40.
//  - Sub-module dht11_bus_sync: 2-FF synchronizer plus registered rise/fall strobes; reused by the host block.
//  - Counter width: $clog2 of the largest timing parameter +1.
// TESTING
//  1. hum=0x2D, temp=0x17, host low 900_000 cycles then release:
//     - Response low begins 3_000 (+2 sync) cycles after release.
//     - Decoded frame is 2D 00 17 00 44; frame_done pulses once.
//  2. Host low only 100_000 cycles: no dht_o_en assertion; busy stays 0; state back in IDLE.
//  3. hum=0xC8, temp=0x64: checksum wraps to 0x2C.
//     - Every '1' high phase measures 7_000 cycles and every '0' measures 2_600.
//  4. rst=1 asserted in the middle of bit 20:
//     - dht_o_en=0 and busy=0 the next cycle.
//     - A following valid start yields a complete, correct frame.
//  5. Change humidity to 0xFF during RESP_HIGH: the frame still carries the value latched at qualification.
//  6. (DHT11_ERR_INJECT_EN) err_inject=1, hum=0x2D, temp=0x17: checksum byte is 0xBB; data bytes unchanged.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types, timing defaults and frame helpers for the DHT11 sensor responder.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOST_LOW  = 3'd1,
        WAIT      = 3'd2,
        RESP_LOW  = 3'd3,
        RESP_HIGH = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        END_LOW   = 3'd7
    } state_t;

    localparam int START_MIN_CYC_DEF = 500_000;
    localparam int WAIT_CYC_DEF      = 3_000;
    localparam int RESP_LOW_CYC_DEF  = 8_000;
    localparam int RESP_HIGH_CYC_DEF = 8_000;
    localparam int BIT_LOW_CYC_DEF   = 5_000;
    localparam int BIT_H0_CYC_DEF    = 2_600;
    localparam int BIT_H1_CYC_DEF    = 7_000;
    localparam int FRAME_BITS        = 40;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Carry is dropped: the DHT11 checksum is the low byte of the sum.
    function automatic logic [7:0] calc_csum(input logic [7:0] hum, input logic [7:0] temp);
        return hum + 8'h00 + temp + 8'h00;
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] hum,
                                                          input logic [7:0] temp,
                                                          input logic       inv);
        logic [7:0] csum;
        csum = calc_csum(hum, temp);
        if (inv) begin
            csum = ~csum;
        end else begin
            csum = csum;
        end
        return {hum, 8'h00, temp, 8'h00, csum};
    endfunction

endpackage

// File: rtl/dht11_bus_sync.sv
// Two-flop synchronizer for the DHT11 bus pad with registered rise/fall strobes
// aligned to the first cycle the synced level changes. Shared with the host block.
module dht11_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state for the synchronizer chain and edge strobes.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        rise_d = meta_q & ~sync_q;
        fall_d = ~meta_q & sync_q;
    end

    // Synchronizer registers; reset to the idle (pulled-up) bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/dht11_sensor_model.sv
// DHT11 device-side responder: qualifies a host start pulse, then sends the response
// preamble and the 40-bit frame. Optional macro DHT11_ERR_INJECT_EN adds err_inject.
module dht11_sensor_model
    import dht11_pkg::*;
#(
    parameter int START_MIN_CYC = START_MIN_CYC_DEF,
    parameter int WAIT_CYC      = WAIT_CYC_DEF,
    parameter int RESP_LOW_CYC  = RESP_LOW_CYC_DEF,
    parameter int RESP_HIGH_CYC = RESP_HIGH_CYC_DEF,
    parameter int BIT_LOW_CYC   = BIT_LOW_CYC_DEF,
    parameter int BIT_H0_CYC    = BIT_H0_CYC_DEF,
    parameter int BIT_H1_CYC    = BIT_H1_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_i,
    output logic       dht_o,
    output logic       dht_o_en,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
`ifdef DHT11_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int MAX_CYC = max_int(max_int(max_int(START_MIN_CYC, WAIT_CYC),
                                             max_int(RESP_LOW_CYC, RESP_HIGH_CYC)),
                                     max_int(BIT_LOW_CYC, max_int(BIT_H0_CYC, BIT_H1_CYC)));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] START_MIN_C = CNT_W'(START_MIN_CYC);
    localparam logic [CNT_W-1:0] WAIT_C      = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] RESP_LOW_C  = CNT_W'(RESP_LOW_CYC);
    localparam logic [CNT_W-1:0] RESP_HIGH_C = CNT_W'(RESP_HIGH_CYC);
    localparam logic [CNT_W-1:0] BIT_LOW_C   = CNT_W'(BIT_LOW_CYC);
    localparam logic [CNT_W-1:0] BIT_H0_C    = CNT_W'(BIT_H0_CYC);
    localparam logic [CNT_W-1:0] BIT_H1_C    = CNT_W'(BIT_H1_CYC);
    localparam logic [5:0]       LAST_BIT    = 6'(FRAME_BITS - 1);

    logic                  bus_s, rise_s, fall_s, inv_s;
    logic [CNT_W-1:0]      lim_s;
    logic                  hit_s;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  en_q, en_d;

    dht11_bus_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (dht_i),
        .sync_o (bus_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

`ifdef DHT11_ERR_INJECT_EN
    assign inv_s = err_inject;
`else
    assign inv_s = 1'b0;
`endif

    // Duration of the current timed phase; the bit-high length follows the bit on the wire.
    always_comb begin
        case (state_q)
            WAIT:      lim_s = WAIT_C;
            RESP_LOW:  lim_s = RESP_LOW_C;
            RESP_HIGH: lim_s = RESP_HIGH_C;
            BIT_LOW:   lim_s = BIT_LOW_C;
            BIT_HIGH:  lim_s = frame_q[FRAME_BITS-1] ? BIT_H1_C : BIT_H0_C;
            END_LOW:   lim_s = BIT_LOW_C;
            default:   lim_s = START_MIN_C;
        endcase
        hit_s = (cnt_q == (lim_s - CNT_W'(1)));
    end

    // Next-state logic for the protocol sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                // A fresh fall or a host already holding the bus both open a count.
                if (fall_s || !bus_s) begin
                    state_d = HOST_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            HOST_LOW: begin
                if (rise_s) begin
                    cnt_d   = '0;
                    state_d = busy_q ? WAIT : IDLE;
                end else if (cnt_q == START_MIN_C) begin
                    cnt_d = cnt_q;
                    if (!busy_q) begin
                        busy_d  = 1'b1;
                        frame_d = build_frame(humidity, temperature, inv_s);
                    end else begin
                        busy_d  = busy_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT, RESP_LOW, BIT_LOW: begin
                if (hit_s) begin
                    cnt_d   = '0;
                    state_d = (state_q == WAIT) ? RESP_LOW :
                              (state_q == RESP_LOW) ? RESP_HIGH : BIT_HIGH;
                end else begin
                    state_d = state_q;
                end
            end
            RESP_HIGH: begin
                if (hit_s) begin
                    cnt_d     = '0;
                    bit_idx_d = 6'd0;
                    state_d   = BIT_LOW;
                end else begin
                    state_d   = RESP_HIGH;
                end
            end
            BIT_HIGH: begin
                if (hit_s) begin
                    cnt_d   = '0;
                    frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = END_LOW;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        state_d   = BIT_LOW;
                    end
                end else begin
                    state_d = BIT_HIGH;
                end
            end
            END_LOW: begin
                if (hit_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = END_LOW;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        en_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 6'd0;
            frame_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_q      <= en_d;
        end
    end

    assign dht_o      = 1'b0;
    assign dht_o_en   = en_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Self-checking bench for dht11_sensor_model with scaled-down timing; decodes the bus.
module tb_dht11_sensor_model;

    localparam int START_MIN = 100;
    localparam int WAIT_C    = 15;
    localparam int RLOW      = 40;
    localparam int RHIGH     = 40;
    localparam int BLOW      = 20;
    localparam int BH0       = 10;
    localparam int BH1       = 30;
    localparam int BUDGET    = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_pull = 1'b0;
    logic       dht_i;
    logic       dht_o, dht_o_en, busy, frame_done;
    logic [7:0] humidity = 8'h00;
    logic [7:0] temperature = 8'h00;
`ifdef DHT11_ERR_INJECT_EN
    logic       err_inject = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_cycles = 0;

    always #5 clk = ~clk;

    // Open-drain bus with pull-up: either side pulling low wins.
    assign dht_i = (dht_o_en ? dht_o : 1'b1) & ~host_pull;

    always @(posedge clk) if (frame_done) done_cycles <= done_cycles + 1;

    dht11_sensor_model #(
        .START_MIN_CYC (START_MIN), .WAIT_CYC (WAIT_C), .RESP_LOW_CYC (RLOW),
        .RESP_HIGH_CYC (RHIGH), .BIT_LOW_CYC (BLOW), .BIT_H0_CYC (BH0), .BIT_H1_CYC (BH1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dht_i       (dht_i),
        .dht_o       (dht_o),
        .dht_o_en    (dht_o_en),
        .humidity    (humidity),
        .temperature (temperature),
`ifdef DHT11_ERR_INJECT_EN
        .err_inject  (err_inject),
`endif
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [7:0] hum;
        logic [7:0] temp;
        int         low_cyc;
        bit         qual;
        logic [7:0] csum;
        bit         err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting for bus activity", name);
    endtask

    // Reference frame from the protocol rules: hum, 0, temp, 0, low byte of the sum.
    function automatic logic [39:0] ref_frame(input logic [7:0] h, input logic [7:0] t, input bit inv);
        int s;
        logic [7:0] c;
        s = (int'(h) + int'(t)) % 256;
        c = 8'(s);
        if (inv) c = ~c;
        return {h, 8'h00, t, 8'h00, c};
    endfunction

    // Counts negedges until dht_o_en reaches lvl.
    task automatic wait_en(input logic lvl, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b1;
        while (dht_o_en !== lvl) begin
            @(negedge clk);
            cycles++;
            if (cycles > BUDGET) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic host_start(input int low_cyc);
        @(negedge clk);
        host_pull = 1'b1;
        repeat (low_cyc) @(negedge clk);
        host_pull = 1'b0;
    endtask

    task automatic decode(input logic [39:0] expf, input bit chg, input logic [7:0] nh,
                          input logic [7:0] nt, input string tag);
        int len, d0, low_bad, high_bad, hlen;
        bit ok, b;
        logic [39:0] got;
        d0 = done_cycles;
        low_bad = 0;
        high_bad = 0;
        got = '0;
        wait_en(1'b1, len, ok);
        if (!ok) begin timeout({tag, " resp_delay"}); return; end
        check_rng({tag, " resp_delay"}, len, WAIT_C + 2, WAIT_C + 4);
        check({tag, " busy_in_frame"}, longint'(busy), 1);
        wait_en(1'b0, len, ok);
        if (!ok) begin timeout({tag, " resp_low"}); return; end
        check({tag, " resp_low_len"}, len, RLOW);
        if (chg) begin
            humidity = nh;
            temperature = nt;
        end
        wait_en(1'b1, len, ok);
        if (!ok) begin timeout({tag, " resp_high"}); return; end
        check({tag, " resp_high_len"}, len, RHIGH);
        for (int i = 0; i < 40; i++) begin
            wait_en(1'b0, len, ok);
            if (!ok) begin timeout({tag, " bit_low"}); return; end
            if (len != BLOW) low_bad++;
            wait_en(1'b1, hlen, ok);
            if (!ok) begin timeout({tag, " bit_high"}); return; end
            b = (hlen > (BH0 + BH1) / 2);
            got = {got[38:0], b};
            if (hlen != (expf[39-i] ? BH1 : BH0)) high_bad++;
        end
        check({tag, " frame"}, longint'(got), longint'(expf));
        check({tag, " bit_low_errs"}, low_bad, 0);
        check({tag, " bit_high_errs"}, high_bad, 0);
        wait_en(1'b0, len, ok);
        if (!ok) begin timeout({tag, " end_low"}); return; end
        check({tag, " end_low_len"}, len, BLOW);
        check({tag, " frame_done_at_end"}, longint'(frame_done), 1);
        @(negedge clk);
        check({tag, " frame_done_pulses"}, done_cycles - d0, 1);
        check({tag, " busy_after"}, longint'(busy), 0);
    endtask

    task automatic glitch(input int low_cyc, input string tag);
        bit en_seen, busy_seen;
        en_seen = 1'b0;
        busy_seen = 1'b0;
        @(negedge clk);
        host_pull = 1'b1;
        for (int i = 0; i < low_cyc + 200; i++) begin
            if (i == low_cyc) host_pull = 1'b0;
            @(negedge clk);
            if (dht_o_en) en_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check({tag, " glitch_no_drive"}, longint'(en_seen), 0);
        check({tag, " glitch_no_busy"}, longint'(busy_seen), 0);
    endtask

    task automatic wait_rises(input int n, output bit ok);
        int seen, cyc;
        logic prev;
        seen = 0;
        cyc = 0;
        ok = 1'b1;
        prev = dht_o_en;
        while (seen < n) begin
            @(negedge clk);
            cyc++;
            if (dht_o_en && !prev) seen++;
            prev = dht_o_en;
            if (cyc > 40 * BUDGET) begin ok = 1'b0; return; end
        end
    endtask

    initial begin
        bit ok;
        int len;
        logic [7:0] h, t;

        vecs.push_back('{8'h2D, 8'h17, 250, 1'b1, 8'h44, 1'b0});
        vecs.push_back('{8'h2D, 8'h17, 40,  1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hC8, 8'h64, 200, 1'b1, 8'h2C, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 300, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 150, 1'b1, 8'h00, 1'b0});
`ifdef DHT11_ERR_INJECT_EN
        vecs.push_back('{8'h2D, 8'h17, 200, 1'b1, 8'hBB, 1'b1});
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset dht_o_en", longint'(dht_o_en), 0);
        check("reset dht_o", longint'(dht_o), 0);
        check("reset busy", longint'(busy), 0);
        check("reset frame_done", longint'(frame_done), 0);

        foreach (vecs[k]) begin
            humidity = vecs[k].hum;
            temperature = vecs[k].temp;
`ifdef DHT11_ERR_INJECT_EN
            err_inject = vecs[k].err;
`endif
            if (vecs[k].qual) begin
                host_start(vecs[k].low_cyc);
                decode({vecs[k].hum, 8'h00, vecs[k].temp, 8'h00, vecs[k].csum},
                       1'b0, 8'h00, 8'h00, $sformatf("vec%0d", k));
            end else begin
                glitch(vecs[k].low_cyc, $sformatf("vec%0d", k));
            end
`ifdef DHT11_ERR_INJECT_EN
            err_inject = 1'b0;
`endif
            repeat (10) @(negedge clk);
        end

        // Humidity changes during the response must not reach the frame in flight.
        humidity = 8'h2D;
        temperature = 8'h17;
        host_start(200);
        decode(ref_frame(8'h2D, 8'h17, 1'b0), 1'b1, 8'hFF, 8'h17, "latch");
        repeat (10) @(negedge clk);

        // Reset in the middle of bit 20, then a clean frame.
        humidity = 8'hA5;
        temperature = 8'h3C;
        host_start(200);
        wait_rises(22, ok);
        if (!ok) begin
            timeout("midreset reach_bit20");
        end else begin
            wait_en(1'b0, len, ok);
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("midreset dht_o_en", longint'(dht_o_en), 0);
            check("midreset busy", longint'(busy), 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (5) @(negedge clk);
            check("midreset idle_no_drive", longint'(dht_o_en), 0);
        end
        humidity = 8'h5A;
        temperature = 8'h21;
        host_start(200);
        decode(ref_frame(8'h5A, 8'h21, 1'b0), 1'b0, 8'h00, 8'h00, "after_reset");
        repeat (10) @(negedge clk);

        // Randomized frames and glitches against the reference model.
        for (int r = 0; r < 6; r++) begin
            h = 8'($urandom);
            t = 8'($urandom);
            humidity = h;
            temperature = t;
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(10, START_MIN - 20), $sformatf("rnd%0d", r));
            end else begin
                host_start($urandom_range(START_MIN + 20, 3 * START_MIN));
                decode(ref_frame(h, t, 1'b0), 1'b1, 8'($urandom), 8'($urandom),
                       $sformatf("rnd%0d", r));
            end
            repeat ($urandom_range(5, 30)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
